// File: rtl/mul_stage.sv
// Two-stage signed multiply/sum stage for a PE datapath: per-lane products in S1,
// exact sign-extended lane sum in S2, with zero-sample tagging and counting.
module mul_stage #(
    parameter int DWd    = 8,
    parameter int NMul   = 4,
    parameter int AuODWd = 2*DWd + $clog2(NMul),
    parameter int CntWd  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cont_reset,
    input  logic                   i_cont_stall,
    input  logic                   i_cont_first_pix,
    input  logic [NMul*DWd-1:0]    i_act,
    input  logic [NMul*DWd-1:0]    i_wt,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [AuODWd-1:0]      o_sum,
    output logic                   o_sum_zero,
    output logic                   o_first_pix,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [CntWd-1:0]       o_zero_cnt
);

    logic                        s1_valid_reg;
    logic                        s1_first_reg;
    logic                        s2_valid_reg;
    logic signed [AuODWd-1:0]    s2_sum_reg;
    logic                        s2_zero_reg;
    logic                        s2_first_reg;
    logic [CntWd-1:0]            zero_cnt_reg;

    logic                        ready_int;
    logic                        s2_adv;
    logic                        s1_adv;
    logic                        accept;
    logic [NMul-1:0]             s1_zero;
    logic signed [2*DWd-1:0]     s1_prod [NMul];
    logic signed [AuODWd-1:0]    sum_next;
    logic                        all_zero;

    // A stall hides downstream readiness so nothing drains while frozen.
    assign ready_int = i_ready & ~i_cont_stall;
    assign s2_adv    = ~s2_valid_reg | ready_int;
    assign s1_adv    = ~s1_valid_reg | s2_adv;
    assign o_ready   = s1_adv & ~i_cont_stall;
    assign accept    = i_valid & o_ready;

    generate
        for (genvar gi = 0; gi < NMul; gi++) begin : gen_lane
            logic signed [DWd-1:0]   act_lane;
            logic signed [DWd-1:0]   wt_lane;
            logic signed [2*DWd-1:0] prod_next;
            logic                    lane_zero;
            logic signed [2*DWd-1:0] prod_reg;
            logic                    zero_reg;

            assign act_lane  = i_act[gi*DWd +: DWd];
            assign wt_lane   = i_wt[gi*DWd +: DWd];
            assign lane_zero = (act_lane == '0) || (wt_lane == '0);
            assign prod_next = (2*DWd)'(act_lane) * (2*DWd)'(wt_lane);

            // Zero lanes load a constant 0 instead of the multiplier result.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    prod_reg <= '0;
                    zero_reg <= 1'b0;
                end else if (accept) begin
                    prod_reg <= lane_zero ? '0 : prod_next;
                    zero_reg <= lane_zero;
                end
            end

            assign s1_prod[gi] = prod_reg;
            assign s1_zero[gi] = zero_reg;
        end
    endgenerate

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NMul; i++) begin
            sum_next = sum_next + AuODWd'(s1_prod[i]);
        end
    end

    assign all_zero = &s1_zero;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_sum_reg   <= '0;
            s2_zero_reg  <= 1'b0;
            s2_first_reg <= 1'b0;
            zero_cnt_reg <= '0;
        end else if (i_cont_reset) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            zero_cnt_reg <= '0;
        end else if (!i_cont_stall) begin
            if (s1_adv) begin
                s1_valid_reg <= accept;
                if (accept) begin
                    s1_first_reg <= i_cont_first_pix;
                end
            end
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_sum_reg   <= sum_next;
                    s2_zero_reg  <= all_zero;
                    s2_first_reg <= s1_first_reg;
                    if (all_zero && (zero_cnt_reg != '1)) begin
                        zero_cnt_reg <= zero_cnt_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign o_valid     = s2_valid_reg;
    assign o_sum       = s2_sum_reg;
    assign o_sum_zero  = s2_zero_reg;
    assign o_first_pix = s2_first_reg;
    assign o_zero_cnt  = zero_cnt_reg;

endmodule

// File: doc/mul_stage.md
MUL_STAGE -- requirements
Module: mul_stage

Interface
REQ-001 SHALL have parameter DWd, default 8: signed activation/weight width.
REQ-002 SHALL have parameter NMul, default 4: multiplier lanes per sample.
REQ-003 SHALL have parameter AuODWd, default 2*DWd+$clog2(NMul): output sum width.
REQ-004 SHALL have parameter CntWd, default 16: zero-sample counter width.
REQ-005 SHALL have port i_clk input 1: sole clock, all logic on rising edge.
REQ-006 SHALL have port i_rst input 1: synchronous, active-high reset.
REQ-007 SHALL have port i_cont_reset input 1: synchronous soft flush from PE controller.
REQ-008 SHALL have port i_cont_stall input 1: global freeze.
REQ-009 SHALL have port i_cont_first_pix input 1: first-pixel tag, sampled with input data.
REQ-010 SHALL have port i_act input NMul*DWd: signed activations, lane k at bits [k*DWd +: DWd].
REQ-011 SHALL have port i_wt input NMul*DWd: signed weights, same lane packing.
REQ-012 SHALL have ports i_valid input 1 and o_ready output 1: input handshake.
REQ-013 SHALL have port o_sum output AuODWd: signed sum of NMul products, feeds the sum stage.
REQ-014 SHALL have port o_sum_zero output 1: every product of this sample was zero.
REQ-015 SHALL have port o_first_pix output 1: i_cont_first_pix, aligned with o_sum.
REQ-016 SHALL have ports o_valid output 1 and i_ready input 1: output handshake.
REQ-017 SHALL have port o_zero_cnt output CntWd: count of accepted all-zero samples.

Function
REQ-018 SHALL transfer input when i_valid && o_ready, and output when o_valid && i_ready.
REQ-019 SHALL be a 2-stage pipeline: S1 registers NMul signed products (2*DWd each), per-lane zero flags and first_pix; S2 registers the adder-tree sum, AND of zero flags, and first_pix.
REQ-020 SHALL have latency exactly 2 cycles, accept to o_valid, with no stall or backpressure; throughput 1 sample/cycle.
REQ-021 SHALL sign-extend products to AuODWd before summing; the sum SHALL be exact (no overflow possible at AuODWd).
REQ-022 SHALL set a lane zero flag when that lane's act==0 or wt==0; with the flag set, the S1 product register SHALL hold 0 and its update SHALL be gated.
REQ-023 SHALL advance S2 when !S2_valid || i_ready, and S1 when !S1_valid || S2 advancing; o_ready SHALL equal the S1 advance condition && !i_cont_stall.
REQ-024 SHALL hold o_sum, o_sum_zero, o_first_pix and o_valid stable while o_valid && !i_ready.
REQ-025 SHALL, while i_cont_stall=1, freeze every register (including o_zero_cnt), force o_ready=0 and treat i_ready as 0 internally; o_valid SHALL keep its value.
REQ-026 SHALL, on i_cont_reset=1, clear S1/S2 valid and o_zero_cnt next cycle, with priority over i_cont_stall and any simultaneous accept; data registers may keep stale values.
REQ-027 SHALL increment o_zero_cnt by 1 when a sample whose lanes are all zero-flagged enters S2, saturating at 2^CntWd-1.
REQ-028 SHALL accept a new sample in the same cycle that S2 drains, when i_ready=1 (full pipeline, no bubble).

Reset
REQ-029 SHALL, when i_rst=1, clear next edge: o_valid=0, o_sum=0, o_sum_zero=0, o_first_pix=0, o_zero_cnt=0, both stage valids=0; o_ready SHALL be 1 in the cycle after i_rst deasserts (if not stalled).
REQ-030 SHALL give i_rst priority over i_cont_reset and i_cont_stall; a mid-flight reset SHALL discard in-flight samples and emit no o_valid for them.

Verification
REQ-031 SHALL verify: act={1,-2,3,4}, wt={5,6,-7,8}, i_ready=1 -> o_valid 2 cycles later, o_sum=5-12-21+32=4, o_sum_zero=0.
REQ-032 SHALL verify: act={-128,-128,-128,-128}, wt={-128,-128,-128,-128} -> o_sum=65536 (AuODWd=18, no overflow).
REQ-033 SHALL verify: act={0,3,0,0}, wt={9,0,7,2} -> o_sum=0, o_sum_zero=1, o_zero_cnt 0->1.
REQ-034 SHALL verify: 3 back-to-back samples with i_ready=0 for 4 cycles -> o_ready drops after 2 accepts, 3rd held at input, all 3 emitted in order once i_ready=1, o_sum stable while blocked.
REQ-035 SHALL verify: i_cont_stall pulse for 3 cycles with 2 samples in flight -> outputs and counter frozen, order and values preserved after release.
REQ-036 SHALL verify: i_cont_reset (and separately i_rst) with full pipeline -> o_valid=0 next cycle, o_zero_cnt=0, the next sample emerges with correct 2-cycle latency.
